// File: rtl/imem_loader_if.sv
// Boot-loader bus: byte-stream input from the host/debug source, the
// instruction-memory write port, and the core control/status outputs.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              core_reset;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] byte_count;

    // Host / byte-source side.
    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  core_reset, done, error, byte_count
    );

    // Loader side.
    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output core_reset, done, error, byte_count
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory boot loader: streams program bytes into memory from
// BASE_ADDR upward while holding the core in reset, then releases the core.
`ifndef IMEM_SIZE
`define IMEM_SIZE 1024
`endif

module imem_loader #(
    parameter int IMEM_SIZE = `IMEM_SIZE,
    parameter int BASE_ADDR = 4,
    parameter int ADDR_W    = 10
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, ERROR} state_t;

    localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(BASE_ADDR);
    // Number of bytes that fit between BASE_ADDR and the top of memory.
    localparam logic [ADDR_W-1:0] CAP_C  = ADDR_W'(IMEM_SIZE - BASE_ADDR);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              in_ready_q, core_reset_q, done_q, error_q;

    // Next state, byte counter and write-port contents for the coming edge.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, RUN, ERROR: begin
                if (bus.start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                // in_ready is high throughout LOAD, so in_valid alone accepts.
                if (bus.in_valid) begin
                    if (count_q == CAP_C) begin
                        // No room left: swallow the byte without writing.
                        state_d = ERROR;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = BASE_C + count_q;
                        wdata_d = bus.in_data;
                        count_d = count_q + 1'b1;
                        if (bus.in_last) begin
                            state_d = RUN;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, write port and status decodes; the decodes are taken
    // from the next state so they are registered yet change on the same edge
    // as the state itself. Reset also kills any write still being presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            in_ready_q   <= 1'b0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            in_ready_q   <= (state_d == LOAD);
            core_reset_q <= (state_d != RUN);
            done_q       <= (state_d == RUN);
            error_q      <= (state_d == ERROR);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.core_reset = core_reset_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.byte_count = count_q;
endmodule
